// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the chunked adder/subtractor.
//
// Contents:
//   state_e : FSM state encoding (IDLE / BUSY / DONE).
//
// The IDLE encoding is 0, so a cleared state register reads as IDLE.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: N-bit ripple-carry adder built from full_adder cells.
//
// Parameters:
//   N        : chunk width in bits
// Ports:
//   a_i, b_i : chunk operands (b_i is already inverted for subtraction)
//   cin_i    : carry into bit 0
//   sum_o    : chunk sum
//   cout_o   : carry out of bit N-1
//   cmsb_o   : carry into bit N-1 (needed for the signed-overflow flag)
module addsub_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);

    logic [N:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (c[i]),
            .s_o (sum_o[i]),
            .c_o (c[i+1])
        );
    end

    assign cout_o = c[N];
    assign cmsb_o = c[N-1];

endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder.
//
// Ports:
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle WIDTH-bit adder/subtractor that processes
// CHUNK bits per clock, LSB chunk first, with a valid/ready interface.
//
// Parameters:
//   WIDTH : operand / result width (must be a multiple of CHUNK)
//   CHUNK : bits added per cycle; latency = WIDTH/CHUNK cycles
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, sub [, sat])
//   a, b                : operands
//   sub                 : 0 = a+b, 1 = a-b
//   out_valid/out_ready : result handshake
//   sum                 : result
//   cout                : carry out of MSB (subtract: 1 = no borrow)
//   ovf                 : two's-complement overflow
//   zero                : sum == 0 (meaningful only while out_valid)
//   dbg_state           : current FSM state (addsub_pkg::state_e encoding)
//   sat                 : saturate on overflow (only with CHUNKED_ADDSUB_SAT_EN)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its payload stable while valid is high and
// not yet accepted; ready never depends combinationally on the same port's valid.
//
// Optional feature macro: CHUNKED_ADDSUB_SAT_EN adds the sat input and
// signed saturation of the result; without it the result always wraps.
module chunked_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef CHUNKED_ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("chunked_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [WIDTH-1:0] sum_wr, sum_d;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    logic             cout_q, ovf_q;
    logic             accept, last, ovf_fin;
    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             c_out, c_msb;
`ifdef CHUNKED_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SAT_MAX = ~SAT_MIN;
    logic             sat_q;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (last)   state_d = DONE;
            DONE: begin
                // A new accept in DONE skips IDLE entirely.
                if (accept)         state_d = BUSY;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
        accept    = in_valid && in_ready;
        last      = (idx_q == LAST_IDX);
    end

    assign dbg_state = state_q;

    // ---------------- chunk datapath ----------------
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    addsub_chunk #(.N(CHUNK)) u_chunk (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (carry_q),
        .sum_o  (s_chunk),
        .cout_o (c_out),
        .cmsb_o (c_msb)
    );

    // Kept separate from the operand mux so the adder output does not feed
    // back into the block that produces its inputs.
    always_comb begin
        sum_wr = sum_q;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                sum_wr[k*CHUNK +: CHUNK] = s_chunk;
            end
        end
    end

    // On the last chunk the carries of the top chunk are those of the MSB.
    always_comb begin
        ovf_fin = c_msb ^ c_out;
        sum_d   = sum_wr;
`ifdef CHUNKED_ADDSUB_SAT_EN
        // Overflow sign always follows A: the true result lies beyond A's side.
        if (last && sat_q && ovf_fin) begin
            sum_d = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef CHUNKED_ADDSUB_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else if (accept) begin
            // Subtraction as A + ~B + 1: invert B and seed the carry with 1.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            idx_q   <= '0;
`ifdef CHUNKED_ADDSUB_SAT_EN
            sat_q   <= sat;
`endif
        end else if (state_q == BUSY) begin
            sum_q   <= sum_d;
            carry_q <= c_out;
            idx_q   <= idx_q + IDXW'(1);
            if (last) begin
                cout_q <= c_out;
                ovf_q  <= ovf_fin;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = (sum_q == '0);

endmodule

// File: tb/tb_chunked_addsub.sv
`timescale 1ns/1ps
module tb_chunked_addsub;
    import addsub_pkg::*;

    localparam int W   = 16;
    localparam int CH  = 4;
    localparam int NCH = W / CH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, sub, sat;
    logic [W-1:0] a, b, sum;
    logic         out_valid, out_ready, cout, ovf, zero;
    logic [1:0]   dbg_state;

    chunked_addsub #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
`ifdef CHUNKED_ADDSUB_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .dbg_state (dbg_state)
    );

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- scoreboard state ----------------
    logic [W+2:0] exp_q[$];   // {sum, cout, ovf, zero}
    int           acc_q[$];   // cycle of the accept edge
    int           n_checks = 0;
    int           n_errors = 0;
    bit           rand_ready_en = 1'b0;
    int           ready_pct = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s, input logic st);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ur, sr;
        logic [W-1:0] r;
        logic c, v;
        if (!s) begin
            ur = ux + uy;
            sr = sx + sy;
            c  = (ur >= (longint'(1) << W));
        end else begin
            ur = ux - uy;
            sr = sx - sy;
            c  = (ux >= uy);
        end
        r = ur[W-1:0];
        v = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
        if (st && v) r = (sx < 0) ? W'(longint'(1) << (W-1)) : W'((longint'(1) << (W-1)) - 1);
        return {r, c, v, (r == '0)};
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic st);
        int   waited = 0;
        bit   ok = 1'b0;
        logic eff_st;
`ifdef CHUNKED_ADDSUB_SAT_EN
        eff_st = st;
`else
        eff_st = 1'b0;
`endif
        in_valid = 1'b1;
        a = x; b = y; sub = s; sat = st;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
            if (waited > 200) begin
                check("accept_timeout", {31'd0, in_ready}, 32'd1);
                break;
            end
        end
        if (ok) begin
            exp_q.push_back(model(x, y, s, eff_st));
            acc_q.push_back(cycle + 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        #1;
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        bit prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                    end else begin
                        if (!prev_valid) check("latency", cycle - acc_q[0], NCH);
                        check("sum",  sum,  exp_q[0][W+2:3]);
                        check("cout", cout, exp_q[0][2]);
                        check("ovf",  ovf,  exp_q[0][1]);
                        check("zero", zero, exp_q[0][0]);
                        check("in_ready_done", in_ready, out_ready);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            void'(acc_q.pop_front());
                        end
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    // Random consumer backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_en) out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners[6];
        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h000F};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return W'($urandom);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready",  in_ready,  1);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum",       sum,       0);
        check("reset_cout",      cout,      0);
        check("reset_ovf",       ovf,       0);
        check("reset_state",     dbg_state, 32'(IDLE));
        @(posedge clk); #1;

        // Directed vectors.
        send(16'h1234, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0003, 1'b1, 1'b0);
        send(16'h0003, 16'h0005, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b1, 1'b1);
        drain();

        // in_valid during BUSY must be ignored.
        send(16'h0100, 16'h0200, 1'b0, 1'b0);
        in_valid = 1'b1; a = 16'hDEAD; b = 16'hBEEF; sub = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("in_ready_busy", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Backpressure: hold result 5 cycles, then release with a new op.
        out_ready = 1'b0;
        send(16'h00AA, 16'h0055, 1'b0, 1'b0);
        begin
            int w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!out_valid && w < 50);
            check("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(16'h4000, 16'h4000, 1'b0, 1'b0);
        drain();

        // Reset in the second BUSY cycle discards the operation.
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_in_ready",  in_ready,  1);
        check("rst_busy_out_valid", out_valid, 0);
        repeat (8) @(posedge clk);
        #1;
        send(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
        drain();

        // Randomized traffic with random backpressure.
        ready_pct = 70;
        rand_ready_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        rand_ready_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/chunked_addsub.md
CHUNKED_ADDSUB -- requirements
Module: chunked_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits processed per cycle; WIDTH mod CHUNK == 0, 1 <= CHUNK <= WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operands and sub valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port sub  input  1  0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-014 SHALL have port ovf  output  1  two's-complement overflow.
REQ-015 SHALL have port zero  output  1  sum == 0.

Function
REQ-016 SHALL be an FSM with states IDLE, BUSY and DONE, with NCHUNK = WIDTH/CHUNK.
REQ-017 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-018 SHALL, on accept (in_valid & in_ready), register a, b XOR {WIDTH{sub}}, carry = sub and chunk index 0, and go to BUSY.
REQ-019 SHALL, in BUSY, add chunk[idx] of A and B' plus the carry each cycle, write the result chunk, update the carry and increment idx.
REQ-020 SHALL go to DONE at the edge that processes chunk NCHUNK-1, capturing cout = the final carry and ovf = carry-into-MSB XOR cout.
REQ-021 SHALL assert out_valid exactly NCHUNK cycles after the accept edge (CHUNK==WIDTH gives latency 1).
REQ-022 SHALL, in DONE, hold out_valid, sum, cout, ovf and zero stable until out_valid & out_ready.
REQ-023 SHALL, on out_valid & out_ready without a new accept, go to IDLE and deassert out_valid the next cycle.
REQ-024 SHALL, on simultaneous out handshake and in_valid in DONE, accept the new operands in the same cycle and go directly to BUSY.
REQ-025 SHALL ignore in_valid while in BUSY; operands are sampled only on the accept edge.
REQ-026 SHALL compute zero combinationally from the registered sum; it is meaningful only while out_valid.

Reset
REQ-027 SHALL, on rst, go to IDLE and clear out_valid, sum, cout, ovf, the carry and idx to 0; in_ready = 1 after reset.
REQ-028 SHALL, if reset is asserted mid-BUSY or in DONE, discard the operation, with no out_valid pulse afterwards.

Configuration
REQ-029 SHALL, with macro CHUNKED_ADDSUB_SAT_EN defined, add port sat (input, 1, sampled on the accept edge).
REQ-030 SHALL, with CHUNKED_ADDSUB_SAT_EN defined and sat=1 & ovf, clamp sum to 0x7F..F when A is non-negative and 0x80..0 when A is negative; ovf still reports the overflow.
REQ-031 SHALL, without the macro, have no sat port and always wrap modulo 2^WIDTH.

Structure
REQ-032 SHALL take the FSM state enum typedef (IDLE/BUSY/DONE) from shared package addsub_pkg.
REQ-033 SHALL implement chunk arithmetic in sub-module addsub_chunk, a CHUNK-bit ripple of the existing full_adder.
REQ-034 SHALL reject a WIDTH not divisible by CHUNK with an elaboration-time error.

Verification (WIDTH=16, CHUNK=4)
REQ-035 SHALL check 0x1234 + 0x0001 -> sum 0x1235, cout 0, ovf 0, zero 0, out_valid exactly 4 cycles after accept.
REQ-036 SHALL check 0x0005 - 0x0003 -> 0x0002, cout 1; and 0x0003 - 0x0005 -> 0xFFFE, cout 0, ovf 0.
REQ-037 SHALL check 0x7FFF + 0x0001 -> 0x8000, ovf 1; with SAT_EN and sat=1 -> 0x7FFF; and 0x8000 - 0x0001 with sat=1 -> 0x8000, ovf 1.
REQ-038 SHALL check 0xFFFF + 0x0001 -> 0x0000, cout 1, zero 1, ovf 0.
REQ-039 SHALL check backpressure: out_ready low 5 cycles -> outputs stable and in_ready 0; then out_ready=1 with in_valid=1 -> new accept that cycle, next result 4 cycles later.
REQ-040 SHALL check rst pulse in BUSY cycle 2 -> out_valid stays 0, in_ready 1 after reset release, and the next operation is correct.
